// File: rtl/mem_arbiter2_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// default geometry, and the round-robin winner selection rule.
package mem_arbiter2_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  // Round-robin pick: on a tie the port not granted last wins, a lone requester always wins.
  function automatic logic pick_winner(input logic en0, input logic en1, input logic last_grant);
    if (en0 && en1) begin
      return ~last_grant;
    end
    return en0 ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter2_spram.sv
// Single-port synchronous RAM: synchronous write, registered read, no reset on the array.
// Ports:
//   clk   - rising-edge clock
//   en    - access enable (one access per enabled edge)
//   we    - 1 = write wdata to addr, 0 = read addr into rdata
//   addr  - word address
//   wdata - write data
//   rdata - registered read data (holds between reads)
module mem_arbiter2_spram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array and read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-port round-robin arbiter in front of one single-port RAM.
// Each granted request walks IDLE -> SERVE -> DONE: the winner's command is
// latched in IDLE, the single RAM access happens at the end of SERVE, and the
// one-cycle ack (with read data on ram_outN) is presented during DONE.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   ram_en0/1, ram_we0/1  - per-port request (held until ack) and write select
//   addr0/1, ram_in0/1    - per-port word address and write data
//   ram_out0/1            - per-port read data, valid with ack, held between acks
//   ram_ack0/1            - per-port one-cycle completion pulse
//   busy                  - high whenever the FSM is not idle
//   grant                 - index of the port being served (held while idle)
module mem_arbiter2
  import mem_arbiter2_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en0,
  input  logic              ram_we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] ram_in0,
  output logic [DATA_W-1:0] ram_out0,
  output logic              ram_ack0,
  input  logic              ram_en1,
  input  logic              ram_we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] ram_in1,
  output logic [DATA_W-1:0] ram_out1,
  output logic              ram_ack1,
  output logic              busy,
  output logic              grant
);

  arb_state_e        state;
  logic              last_grant;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;
  logic [DATA_W-1:0] rdata;
  logic              win_c;
  logic              mem_en_c;

  always_comb win_c = pick_winner(ram_en0, ram_en1, last_grant);

  // The reset term kills a write that would otherwise land on the reset edge.
  always_comb mem_en_c = (state == ST_SERVE) && !rst;

  mem_arbiter2_spram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_spram (
    .clk  (clk),
    .en   (mem_en_c),
    .we   (we_q),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  // Arbitration FSM with registered control outputs and per-port read-data holders.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      busy       <= 1'b0;
      ram_ack0   <= 1'b0;
      ram_ack1   <= 1'b0;
      hold0      <= '0;
      hold1      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      ram_ack0 <= 1'b0;
      ram_ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ram_en0 || ram_en1) begin
            state      <= ST_SERVE;
            busy       <= 1'b1;
            grant      <= win_c;
            last_grant <= win_c;
            we_q       <= win_c ? ram_we1 : ram_we0;
            addr_q     <= win_c ? addr1   : addr0;
            wdata_q    <= win_c ? ram_in1 : ram_in0;
          end
        end
        ST_SERVE: begin
          state <= ST_DONE;
          if (grant) begin
            ram_ack1 <= 1'b1;
          end else begin
            ram_ack0 <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!we_q) begin
            if (grant) begin
              hold1 <= rdata;
            end else begin
              hold0 <= rdata;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // During the ack of a read the RAM read register is shown directly; otherwise the held value.
  always_comb begin
    ram_out0 = hold0;
    ram_out1 = hold1;
    if ((state == ST_DONE) && !we_q) begin
      if (grant) begin
        ram_out1 = rdata;
      end else begin
        ram_out0 = rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
module tb_mem_arbiter2;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ram_en0 = 1'b0, ram_we0 = 1'b0, ram_en1 = 1'b0, ram_we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] ram_in0 = '0, ram_in1 = '0;
  logic [DW-1:0] ram_out0, ram_out1;
  logic          ram_ack0, ram_ack1, busy, grant;

  mem_arbiter2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ram_en0(ram_en0), .ram_we0(ram_we0), .addr0(addr0), .ram_in0(ram_in0),
    .ram_out0(ram_out0), .ram_ack0(ram_ack0),
    .ram_en1(ram_en1), .ram_we1(ram_we1), .addr1(addr1), .ram_in1(ram_in1),
    .ram_out1(ram_out1), .ram_ack1(ram_ack1),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack0_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a granted request occupies the RAM for three cycles,
  // its effect and ack land one edge after the grant, the port is free two edges later.
  logic [31:0] m_mem [256];
  int          age = -1;
  logic        m_last = 1'b1;
  logic        t_port, t_we;
  logic [7:0]  t_addr;
  logic [31:0] t_data;
  logic        e_ack0 = 1'b0, e_ack1 = 1'b0, e_busy = 1'b0, e_grant = 1'b0;
  logic [31:0] e_out0 = '0, e_out1 = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      age = -1; m_last = 1'b1; e_grant = 1'b0; e_busy = 1'b0;
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_out0 = '0; e_out1 = '0;
    end else begin
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      if (age < 0) begin
        if (ram_en0 || ram_en1) begin
          if (ram_en0 && ram_en1) t_port = (m_last == 1'b1) ? 1'b0 : 1'b1;
          else                    t_port = ram_en1;
          t_we   = t_port ? ram_we1 : ram_we0;
          t_addr = t_port ? addr1 : addr0;
          t_data = t_port ? ram_in1 : ram_in0;
          m_last = t_port; e_grant = t_port; e_busy = 1'b1; age = 0;
        end
      end else begin
        age++;
        if (age == 1) begin
          if (t_we) m_mem[t_addr] = t_data;
          else if (t_port) e_out1 = m_mem[t_addr];
          else e_out0 = m_mem[t_addr];
          if (t_port) e_ack1 = 1'b1; else e_ack0 = 1'b1;
        end else begin
          age = -1;
          e_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("ack0", 32'(ram_ack0), 32'(e_ack0));
      chk("ack1", 32'(ram_ack1), 32'(e_ack1));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("grant", 32'(grant), 32'(e_grant));
      chk("out0", ram_out0, e_out0);
      chk("out1", ram_out1, e_out1);
      if (ram_ack0) ack0_log.push_back(cyc);
    end
  end

  // Issue one request on port p and hold it until ack (+hold extra cycles).
  // lat = index of the ack cycle, counting the first request cycle as 1.
  task automatic port_txn(input bit p, input bit we, input int addr, input logic [31:0] data,
                          input int hold, output int lat, output logic [31:0] rd);
    int n = 0;
    if (!p) begin ram_en0 = 1'b1; ram_we0 = we; addr0 = AW'(addr); ram_in0 = data; end
    else    begin ram_en1 = 1'b1; ram_we1 = we; addr1 = AW'(addr); ram_in1 = data; end
    do begin
      @(posedge clk); #1; n++;
    end while (!(p ? ram_ack1 : ram_ack0) && n < 30);
    if (!(p ? ram_ack1 : ram_ack0)) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout port%0d: got no ack after %0d cycles, required an ack", p, n);
    end
    lat = n + 1;
    rd  = p ? ram_out1 : ram_out0;
    repeat (1 + hold) @(posedge clk);
    #1;
    if (!p) ram_en0 = 1'b0; else ram_en1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int l0, l1;
    logic [31:0] r0, r1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(ram_ack0), 32'd0);
    chk("rst_ack1", 32'(ram_ack1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_out0", ram_out0, 32'd0);
    chk("rst_out1", ram_out1, 32'd0);
    rst = 1'b0;

    // Simultaneous pair right after reset: port 0 first.
    fork
      port_txn(1'b0, 1'b1, 'h01, 32'h11111111, 0, l0, r0);
      port_txn(1'b1, 1'b1, 'h02, 32'h22222222, 0, l1, r1);
    join
    chk("pairA_lat0", 32'(l0), 32'd3);
    chk("pairA_lat1", 32'(l1), 32'd6);

    // Lone port 0 request, then a second pair: port 1 first.
    port_txn(1'b0, 1'b0, 'h02, '0, 0, l0, r0);
    chk("lone_lat0", 32'(l0), 32'd3);
    chk("lone_rd0", r0, 32'h22222222);
    fork
      port_txn(1'b0, 1'b0, 'h01, '0, 0, l0, r0);
      port_txn(1'b1, 1'b0, 'h02, '0, 0, l1, r1);
    join
    chk("pairB_lat1", 32'(l1), 32'd3);
    chk("pairB_rd1", r1, 32'h22222222);
    chk("pairB_lat0", 32'(l0), 32'd6);
    chk("pairB_rd0", r0, 32'h11111111);

    // Write then read back on port 0.
    port_txn(1'b0, 1'b1, 'h10, 32'hDEADBEEF, 0, l0, r0);
    chk("wr10_lat", 32'(l0), 32'd3);
    port_txn(1'b0, 1'b0, 'h10, '0, 0, l0, r0);
    chk("rd10_lat", 32'(l0), 32'd3);
    chk("rd10_data", r0, 32'hDEADBEEF);

    // Write/read race on 0xFF: port 0 wins the tie, so it sees the prior value.
    port_txn(1'b1, 1'b1, 'hFF, 32'hCAFEF00D, 0, l1, r1);
    fork
      port_txn(1'b0, 1'b0, 'hFF, '0, 0, l0, r0);
      port_txn(1'b1, 1'b1, 'hFF, 32'h12345678, 0, l1, r1);
    join
    chk("raceFF_rd0", r0, 32'hCAFEF00D);
    chk("raceFF_lat1", 32'(l1), 32'd6);
    port_txn(1'b0, 1'b0, 'hFF, '0, 0, l0, r0);
    chk("rdFF_after", r0, 32'h12345678);

    // Enable held two extra cycles after ack: a second access, ack 3 cycles later.
    ack0_log.delete();
    port_txn(1'b0, 1'b0, 'h10, '0, 2, l0, r0);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_ack_count", 32'(ack0_log.size()), 32'd2);
    if (ack0_log.size() == 2) chk("hold_ack_gap", 32'(ack0_log[1] - ack0_log[0]), 32'd3);

    // Reset during SERVE of a write aborts it.
    port_txn(1'b0, 1'b1, 'h20, 32'h0BADF00D, 0, l0, r0);
    ram_en0 = 1'b1; ram_we0 = 1'b1; addr0 = 8'h20; ram_in0 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1; ram_en0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ack0", 32'(ram_ack0), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out0", ram_out0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    port_txn(1'b0, 1'b0, 'h20, '0, 0, l0, r0);
    chk("abort_rd20", r0, 32'h0BADF00D);

    // Address 0x100 wraps to 0x00 with an 8-bit address.
    port_txn(1'b0, 1'b1, 'h100, 32'h5A5A0100, 0, l0, r0);
    port_txn(1'b1, 1'b0, 'h00, '0, 0, l1, r1);
    chk("wrap_rd00", r1, 32'h5A5A0100);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
